// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer
//   Frame-level sequencer for the 64-point in-place FFT core. Produces the frame
//   counter cnt and its advance strobe step for the bank/stage control logic,
//   and wraps the fixed 2**CNT_W-count frame (load, compute, unload) in
//   valid/ready handshakes on the input and output sides.
//
// Ports
//   clk          clock, all logic on the rising edge
//   nrst         synchronous active-low reset
//   start        begin a frame (honoured only in IDLE)
//   abort        abandon the current frame and return to IDLE
//   cont         1: chain frames back-to-back, 0: stop in IDLE after each frame
//   in_valid     input sample present
//   in_ready     input sample accepted when in_valid & in_ready
//   out_ready    downstream accepts the output sample
//   out_valid    output sample present (unload phase)
//   out_last     final output sample of the frame
//   cnt          frame counter to the control logic
//   step         cnt advances at this edge
//   busy         sequencer is not IDLE
//   frame_done   one-cycle pulse after the last output handshake
//   frame_cnt    completed frames, wraps
//   in_stall_cnt / out_stall_cnt  (only with FFT_SEQ_STALL_CNT_EN defined)
//                saturating counts of LOAD cycles without in_valid and of
//                UNLOAD cycles without out_ready
//
// Optional feature macro: FFT_SEQ_STALL_CNT_EN
module fft_frame_sequencer #(
  parameter int CNT_W     = 8,
  parameter int LOAD_LAST = 63,
  parameter int CALC_LAST = 223,
  parameter int FCNT_W    = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic              abort,
  input  logic              cont,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              out_ready,
  output logic              out_valid,
  output logic              out_last,
  output logic [CNT_W-1:0]  cnt,
  output logic              step,
  output logic              busy,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_cnt
`ifdef FFT_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]       in_stall_cnt,
  output logic [15:0]       out_stall_cnt
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] CALC   = 2'd2;
  localparam logic [1:0] UNLOAD = 2'd3;

  localparam logic [CNT_W-1:0] LOAD_END = CNT_W'(LOAD_LAST);
  localparam logic [CNT_W-1:0] CALC_END = CNT_W'(CALC_LAST);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [1:0] state;

  // Handshake and strobe outputs decode straight from state/cnt so the
  // control logic sees step in the same cycle the handshake happens.
  always_comb begin
    busy      = (state != IDLE);
    in_ready  = (state == LOAD);
    out_valid = (state == UNLOAD);
    out_last  = (state == UNLOAD) && (cnt == CNT_MAX);
    step      = 1'b0;
    case (state)
      LOAD:    step = in_valid;
      CALC:    step = 1'b1;
      UNLOAD:  step = out_ready;
      default: step = 1'b0;
    endcase
  end

  // Main sequencer. abort beats everything except reset, including the final
  // output handshake, so an aborted frame is never counted as done.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state      <= IDLE;
      cnt        <= '0;
      frame_cnt  <= '0;
      frame_done <= 1'b0;
    end else if (abort) begin
      state      <= IDLE;
      cnt        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start) state <= LOAD;
        end
        LOAD: begin
          if (in_valid) begin
            cnt <= cnt + 1'b1;
            if (cnt == LOAD_END) state <= CALC;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (cnt == CALC_END) state <= UNLOAD;
        end
        UNLOAD: begin
          if (out_ready) begin
            // cnt wraps to 0 on the last handshake, ready for the next frame
            cnt <= cnt + 1'b1;
            if (cnt == CNT_MAX) begin
              frame_cnt  <= frame_cnt + 1'b1;
              frame_done <= 1'b1;
              state      <= cont ? LOAD : IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef FFT_SEQ_STALL_CNT_EN
  // Stall statistics: cleared when a new frame is accepted from IDLE,
  // saturating so a long stall never wraps back to a small value.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      in_stall_cnt  <= '0;
      out_stall_cnt <= '0;
    end else if ((state == IDLE) && start && !abort) begin
      in_stall_cnt  <= '0;
      out_stall_cnt <= '0;
    end else begin
      if ((state == LOAD) && !in_valid && (in_stall_cnt != 16'hFFFF))
        in_stall_cnt <= in_stall_cnt + 16'd1;
      if ((state == UNLOAD) && !out_ready && (out_stall_cnt != 16'hFFFF))
        out_stall_cnt <= out_stall_cnt + 16'd1;
    end
  end
`endif

endmodule
